mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the 5-stage MIPS pipeline.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_core.sv | 65 ++++++
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, cycle defaults and result type for the multiply/divide unit
package mdu_pkg;

    // 3-bit md op encodings (also used by D-stage hazard classification)
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MADDU = 3'd7
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // {HI,LO} as one 64-bit value
    typedef logic [63:0] mdu_res_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational 64-bit multiply/divide/madd result plus divide-by-zero flag
//
// Ports:
//   op          in   md op (mdu_op_e)
//   a, b        in   rs / rt operands
//   hi, lo      in   committed HI/LO (accumulator for madd, pass-through otherwise)
//   result      out  {HI,LO} value the op would produce
//   div_by_zero out  div/divu with b==0
// Config: MDU_MADD_EN enables the MDU_MADD / MDU_MADDU datapath.
module mdu_core
    import mdu_pkg::*;
(
    input  mdu_op_e      op,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  hi,
    input  logic [31:0]  lo,
    output mdu_res_t     result,
    output logic         div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        // Sign-extend to 64 bits so the truncated 64x64 product is the exact signed product
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        // Divide on magnitudes; 0x80000000's magnitude fits in 32 unsigned bits,
        // so 0x80000000 / -1 lands on quotient 0x80000000 without overflow.
        is_signed_div = (op == MDU_DIV);
        a_mag = (is_signed_div && a[31]) ? (32'd0 - a) : a;
        b_mag = (is_signed_div && b[31]) ? (32'd0 - b) : b;
        div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
        b_div = (b == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        // Truncate toward zero; remainder follows the dividend's sign
        quot = (is_signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        rem  = (is_signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;

        result = {hi, lo};
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV,
            MDU_DIVU:  result = {rem, quot};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = {hi, lo} + prod_s;
            MDU_MADDU: result = {hi, lo} + prod_u;
`endif
            default:   result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers (E stage)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   E_start  in   E-stage md op valid
//   E_op     in   md op encoding (mdu_pkg::mdu_op_e)
//   E_A      in   rs operand
//   E_B      in   rt operand
//   E_rd_hi  in   1: rd_data=HI, 0: rd_data=LO
//   busy     out  multi-cycle op in flight
//   HI, LO   out  committed HI/LO
//   rd_data  out  combinational HI/LO read mux
// Config: MDU_MADD_EN adds madd/maddu; undefined, those encodings are no-ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_rd_hi,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rd_data
);

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mdu_res_t    pending_q, pending_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    mdu_op_e     op;
    mdu_res_t    core_result;
    logic        core_dbz;
    logic        is_long;
    logic        is_div;

    assign op = mdu_op_e'(E_op);

    mdu_core u_core (
        .op          (op),
        .a           (E_A),
        .b           (E_B),
        .hi          (hi_q),
        .lo          (lo_q),
        .result      (core_result),
        .div_by_zero (core_dbz)
    );

    always_comb begin
        is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
        is_long = is_div || (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        if ((op == MDU_MADD) || (op == MDU_MADDU)) begin
            is_long = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (E_start) begin
                    if (is_long) begin
                        // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged
                        pending_d = core_dbz ? {hi_q, lo_q} : core_result;
                        cnt_d     = is_div ? DIV_LAST : MULT_LAST;
                        state_d   = MDU_RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_d = E_A;
                    end else if (op == MDU_MTLO) begin
                        lo_d = E_A;
                    end
                end
            end
            MDU_RUN: begin
                // E_start here is a protocol violation and is deliberately ignored
                if (cnt_q == 4'd0) begin
                    {hi_d, lo_d} = pending_q;
                    state_d      = MDU_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= 4'd0;
            pending_q <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q == MDU_RUN);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign rd_data = E_rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit (honours MDU_MADD_EN)
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_rd_hi;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .E_start (E_start),
        .E_op    (E_op),
        .E_A     (E_A),
        .E_B     (E_B),
        .E_rd_hi (E_rd_hi),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op; returns the number of cycles busy stayed high (bounded at 40)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        E_op = op; E_A = a; E_B = b; E_start = 1'b1;
        @(posedge clk); #1;
        E_start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; E_start = 1'b0; E_op = 3'd0; E_A = 32'd0; E_B = 32'd0; E_rd_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult();
        int c;
        run_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, c);
        checks++; if (c !== 5) begin errors++; $display("FAIL mult_cycles got=%0d exp=5", c); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffe", LO); end
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, c);
        checks++; if (c !== 5) begin errors++; $display("FAIL multu_cycles got=%0d exp=5", c); end
        checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
        E_rd_hi = 1'b1; #1;
        checks++; if (rd_data !== 32'h00000001) begin errors++; $display("FAIL rd_hi got=%h exp=00000001", rd_data); end
        E_rd_hi = 1'b0; #1;
        checks++; if (rd_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL rd_lo got=%h exp=fffffffe", rd_data); end
    endtask

    task automatic test_div();
        int c;
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL div_cycles got=%0d exp=10", c); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
        run_op(MDU_DIVU, 32'd7, 32'd2, c);
        checks++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo got=%h exp=3", LO); end
        checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi got=%h exp=1", HI); end
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, c);
        checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL divovf_hi got=%h exp=0", HI); end
    endtask

    task automatic test_div_zero();
        int c;
        run_op(MDU_MTLO, 32'h1234, 32'd0, c);
        checks++; if (c !== 0) begin errors++; $display("FAIL mtlo_busy got=%0d exp=0", c); end
        checks++; if (LO !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got=%h exp=1234", LO); end
        run_op(MDU_MTHI, 32'h5678, 32'd0, c);
        checks++; if (HI !== 32'h5678) begin errors++; $display("FAIL mthi_hi got=%h exp=5678", HI); end
        run_op(MDU_DIV, 32'd5, 32'd0, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL div0_cycles got=%0d exp=10", c); end
        checks++; if (LO !== 32'h1234) begin errors++; $display("FAIL div0_lo got=%h exp=1234", LO); end
        checks++; if (HI !== 32'h5678) begin errors++; $display("FAIL div0_hi got=%h exp=5678", HI); end
    endtask

    task automatic test_start_while_busy();
        int c;
        @(negedge clk);
        E_op = MDU_MULT; E_A = 32'hFFFFFFFF; E_B = 32'd2; E_start = 1'b1;
        @(posedge clk); #1;
        E_start = 1'b0;
        c = 1;
        @(negedge clk);
        E_op = MDU_MULTU; E_A = 32'd3; E_B = 32'd3; E_start = 1'b1;
        @(posedge clk); #1;
        E_start = 1'b0;
        c = 2;
        checks++; if (HI !== 32'h5678 || LO !== 32'h1234) begin
            errors++; $display("FAIL busy_early_commit got=%h_%h exp=00005678_00001234", HI, LO);
        end
        while (busy === 1'b1 && c < 40) begin
            @(posedge clk); #1;
            if (busy === 1'b1) c++;
        end
        checks++; if (c !== 5) begin errors++; $display("FAIL busy_cycles got=%0d exp=5", c); end
        checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL busy_result got=%h_%h exp=ffffffff_fffffffe", HI, LO);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignored_restart got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        E_op = MDU_MULT; E_A = 32'd3; E_B = 32'd4; E_start = 1'b1;
        @(posedge clk); #1;
        E_start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", HI, LO);
        end
        @(negedge clk); reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL rstmid_nocommit got=%b %h_%h exp=0 0_0", busy, HI, LO);
        end
    endtask

    task automatic test_madd();
        int c;
        run_op(MDU_MTHI, 32'd0, 32'd0, c);
        run_op(MDU_MTLO, 32'hFFFFFFFF, 32'd0, c);
        run_op(MDU_MADD, 32'd1, 32'd1, c);
`ifdef MDU_MADD_EN
        checks++; if (c !== 5) begin errors++; $display("FAIL madd_cycles got=%0d exp=5", c); end
        checks++; if (HI !== 32'd1 || LO !== 32'd0) begin
            errors++; $display("FAIL madd_result got=%h_%h exp=00000001_00000000", HI, LO);
        end
`else
        checks++; if (c !== 0) begin errors++; $display("FAIL madd_noop_busy got=%0d exp=0", c); end
        checks++; if (HI !== 32'd0 || LO !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL madd_noop_result got=%h_%h exp=00000000_ffffffff", HI, LO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_run();
        test_madd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
